// File: rtl/lsu_mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_adapter
// Purpose  : Load/store adapter between the RV32I memory stage and a
//            zero-delay, big-endian, byte-addressed RAM. Each request takes
//            one valid/ready handshake. Loads are extracted and extended.
//            Byte and halfword stores are read-modify-write merged, because
//            the RAM only accepts full words.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_adapter #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [dataW-1:0]       req_wdata,
    output logic                   resp_valid,
    output logic [dataW-1:0]       resp_rdata,
    output logic                   resp_err,
    output logic [RAMAddrSize-1:0] ram_addr,
    output logic [dataW-1:0]       ram_wdata,
    output logic                   ram_we,
    input  logic [dataW-1:0]       ram_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   write_q;
    logic [2:0]             funct3_q;
    logic [RAMAddrSize-1:0] addr_q;
    // Holds the raw store data until READ, then the merged word for WRITE.
    logic [dataW-1:0]       wdata_q;
    logic [dataW-1:0]       resp_rdata_q;
    logic                   resp_err_q;

    logic                   w_accept;
    logic                   w_addr_err;
    logic                   w_f3_err;
    logic                   w_req_err;
    logic [dataW-1:0]       w_load_data;
    logic [dataW-1:0]       w_merge_data;

    assign w_accept   = req_valid && (state_q == c_IDLE);
    assign w_addr_err = |req_addr[31:RAMAddrSize];
    assign w_req_err  = w_addr_err || w_f3_err;

    // Classify funct3 legality for the requested direction.
    always_comb begin
        w_f3_err = 1'b1;
        if (req_write) begin
            w_f3_err = !((req_funct3 == c_F3_B) || (req_funct3 == c_F3_H) ||
                         (req_funct3 == c_F3_W));
        end else begin
            w_f3_err = !((req_funct3 == c_F3_B)  || (req_funct3 == c_F3_H)  ||
                         (req_funct3 == c_F3_W)  || (req_funct3 == c_F3_BU) ||
                         (req_funct3 == c_F3_HU));
        end
    end

    // State register; an asynchronous reset aborts any transfer in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: SW skips READ, sub-word stores do READ then WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        state_d = c_RESP;
                    end else if (req_write && (req_funct3 == c_F3_W)) begin
                        state_d = c_WRITE;
                    end else begin
                        state_d = c_READ;
                    end
                end
            end
            c_READ:  state_d = write_q ? c_WRITE : c_RESP;
            c_WRITE: state_d = c_RESP;
            c_RESP:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Strobes decoded from registered state only, never from req_* inputs.
    always_comb begin
        req_ready  = (state_q == c_IDLE);
        resp_valid = (state_q == c_RESP);
        ram_we     = (state_q == c_WRITE);
    end

    // Big-endian extraction: the addressed byte sits in ram_rdata[31:24].
    always_comb begin
        w_load_data = '0;
        case (funct3_q)
            c_F3_B:  w_load_data = {{24{ram_rdata[31]}}, ram_rdata[31:24]};
            c_F3_BU: w_load_data = {24'd0, ram_rdata[31:24]};
            c_F3_H:  w_load_data = {{16{ram_rdata[31]}}, ram_rdata[31:16]};
            c_F3_HU: w_load_data = {16'd0, ram_rdata[31:16]};
            c_F3_W:  w_load_data = ram_rdata;
            default: w_load_data = '0;
        endcase
    end

    // Sub-word store merge: new data replaces the leading bytes of the old word.
    always_comb begin
        w_merge_data = ram_rdata;
        if (funct3_q == c_F3_H) begin
            w_merge_data = {wdata_q[15:0], ram_rdata[15:0]};
        end else begin
            w_merge_data = {wdata_q[7:0], ram_rdata[23:0]};
        end
    end

    // Request latching, store merge capture and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (w_accept) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[RAMAddrSize-1:0];
                        wdata_q  <= req_wdata;
                        if (w_req_err) begin
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                c_READ: begin
                    if (write_q) begin
                        wdata_q <= w_merge_data;
                    end else begin
                        resp_rdata_q <= w_load_data;
                        resp_err_q   <= 1'b0;
                    end
                end
                c_WRITE: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_adapter
// Purpose  : Directed vector bench for lsu_mem_adapter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_adapter;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [7:0]  mem [0:65535];
    logic [15:0] a1, a2, a3;

    int n_cmp;
    int n_fail;

    lsu_mem_adapter #(.dataW(32), .RAMAddrSize(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Big-endian, byte-addressed, wrapping RAM with combinational read.
    assign a1 = ram_addr + 16'd1;
    assign a2 = ram_addr + 16'd2;
    assign a3 = ram_addr + 16'd3;
    assign ram_rdata = {mem[ram_addr], mem[a1], mem[a2], mem[a3]};

    always @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata[31:24];
            mem[a1]       <= ram_wdata[23:16];
            mem[a2]       <= ram_wdata[15:8];
            mem[a3]       <= ram_wdata[7:0];
        end
    end

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_ram_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for its response strobe; lat counts the
    // cycles from the acceptance edge to the cycle where resp_valid is high.
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat, output int we_cnt, output logic [31:0] ram_wd);
        int guard;
        rd = '0; err = 1'b0; lat = -1; we_cnt = 0; ram_wd = '0;
        @(negedge clock);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (ram_we) begin
                we_cnt++;
                ram_wd = ram_wdata;
            end
            if (resp_valid) begin
                rd  = resp_rdata;
                err = resp_err;
                lat = k + 1;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rd, ramwd;
        logic        err;
        int          lat, wec, guard;
        logic [8:0]  acc_mask;

        n_cmp = 0; n_fail = 0;
        req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h80; mem[16'h11] = 8'h12; mem[16'h12] = 8'h34; mem[16'h13] = 8'h56;
        mem[16'h20] = 8'hAA; mem[16'h21] = 8'h11; mem[16'h22] = 8'h22; mem[16'h23] = 8'h33;
        mem[16'h24] = 8'h44; mem[16'h25] = 8'hBB;
        mem[16'h50] = 8'h11; mem[16'h51] = 8'h22; mem[16'h52] = 8'h33; mem[16'h53] = 8'h44;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata,          32'd0);
        chk("rst resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst ram_we",     {31'd0, ram_we},     32'd0);
        chk("rst ram_addr",   {16'd0, ram_addr},   32'd0);
        chk("rst ram_wdata",  ram_wdata,           32'd0);
        @(negedge clock);
        reset = 1'b0;

        //               wr  f3      addr           wdata          exp_rd         err lat we  ram_wd
        vecs.push_back('{0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FF80, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b100, 32'h0000_0010, 32'h0,         32'h0000_0080, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b001, 32'h0000_0010, 32'h0,         32'hFFFF_8012, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_8012, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b010, 32'h0000_0010, 32'h0,         32'h8012_3456, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b000, 32'h0000_0011, 32'h0,         32'h0000_0012, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b001, 32'h0000_0012, 32'h0,         32'h0000_3456, 0,  2,  0,  32'h0});
        vecs.push_back('{1, 3'b000, 32'h0000_0010, 32'h0000_00AB, 32'h0,         0,  3,  1,  32'hAB12_3456});
        vecs.push_back('{0, 3'b010, 32'h0000_0010, 32'h0,         32'hAB12_3456, 0,  2,  0,  32'h0});
        vecs.push_back('{1, 3'b001, 32'h0000_0021, 32'h0000_CAFE, 32'h0,         0,  3,  1,  32'hCAFE_3344});
        vecs.push_back('{0, 3'b010, 32'h0000_0020, 32'h0,         32'hAACA_FE33, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b010, 32'h0000_0022, 32'h0,         32'hFE33_44BB, 0,  2,  0,  32'h0});
        vecs.push_back('{1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         0,  2,  1,  32'hDEAD_BEEF});
        vecs.push_back('{0, 3'b010, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0,  2,  0,  32'h0});
        vecs.push_back('{1, 3'b001, 32'h0000_0030, 32'hFFFF_1234, 32'h0,         0,  3,  1,  32'h1234_0000});
        vecs.push_back('{0, 3'b010, 32'h0000_0030, 32'h0,         32'h1234_0000, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{0, 3'b010, 32'h0001_0000, 32'h0,         32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{0, 3'b111, 32'h0000_0010, 32'h0,         32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{1, 3'b100, 32'h0000_0010, 32'h1111_1111, 32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{1, 3'b010, 32'h0002_0040, 32'h1111_1111, 32'h0,         1,  1,  0,  32'h0});
        vecs.push_back('{1, 3'b010, 32'h0000_FFFE, 32'h0102_0304, 32'h0,         0,  2,  1,  32'h0102_0304});
        vecs.push_back('{0, 3'b010, 32'h0000_FFFE, 32'h0,         32'h0102_0304, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b100, 32'h0000_0001, 32'h0,         32'h0000_0004, 0,  2,  0,  32'h0});
        vecs.push_back('{0, 3'b010, 32'h0000_0010, 32'h0,         32'hAB12_3456, 0,  2,  0,  32'h0});

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, err, lat, wec, ramwd);
            chk($sformatf("v%0d rdata", i),   rd,             vecs[i].exp_rd);
            chk($sformatf("v%0d err", i),     {31'd0, err},   {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d latency", i), lat,            vecs[i].exp_lat);
            chk($sformatf("v%0d we_count", i), wec,           vecs[i].exp_we);
            if (vecs[i].exp_we != 0)
                chk($sformatf("v%0d ram_wdata", i), ramwd, vecs[i].exp_ram_wd);
        end

        // Untouched neighbours of the SH at 0x21.
        chk("sh neighbour 0x20", {24'd0, mem[16'h20]}, 32'h0000_00AA);
        chk("sh neighbour 0x25", {24'd0, mem[16'h25]}, 32'h0000_00BB);

        // req_valid held high across loads: one acceptance every 3 cycles.
        @(negedge clock);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 0;
        acc_mask = '0;
        for (int c = 0; c < 9; c++) begin
            acc_mask[c] = req_ready;
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("b2b accept pattern", {23'd0, acc_mask}, 32'h0000_0049);
        repeat (3) @(negedge clock);
        chk("b2b last rdata", resp_rdata, 32'hAB12_3456);

        // Reset during READ of an SB: no write, no response.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'hEE;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rstREAD ram_we",     {31'd0, ram_we},     32'd0);
        chk("rstREAD resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("rstREAD hold ram_we", {31'd0, ram_we}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstREAD req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstREAD mem", {mem[16'h50], mem[16'h51], mem[16'h52], mem[16'h53]}, 32'h1122_3344);

        // Reset during WRITE: ram_we must drop immediately, memory untouched.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'hEE;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rstWRITE we before", {31'd0, ram_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstWRITE we after",  {31'd0, ram_we},     32'd0);
        chk("rstWRITE resp",      {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstWRITE req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstWRITE mem", {mem[16'h50], mem[16'h51], mem[16'h52], mem[16'h53]}, 32'h1122_3344);
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("rstWRITE no resp", {31'd0, resp_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
